// File: rtl/video_timing_regen.sv
// rtl/video_timing_regen.sv - display timing regenerator phase-locked to camera href/vsync
module video_timing_regen #(
    parameter int CNT_W        = 12,
    parameter int H_ACT        = 1280,
    parameter int H_FP         = 110,
    parameter int H_SYNC       = 40,
    parameter int V_ACT        = 720,
    parameter int V_FP         = 5,
    parameter int V_SYNC       = 5,
    parameter int H_TOTAL_FREE = 1650,
    parameter int V_TOTAL      = 750,
    parameter int LOCK_LINES   = 2,
    parameter int TIMEOUT      = 4096,
    parameter int HS_POL       = 1,
    parameter int VS_POL       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_href,
    input  logic             cam_vsync,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] line_len,
    output logic             locked
);

    localparam int MC_W = $clog2(LOCK_LINES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] H_MIN    = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_FREE   = CNT_W'(H_TOTAL_FREE);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_SAT   = TO_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_LOCK  = MC_W'(LOCK_LINES);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    typedef enum logic [1:0] {
        S_FREE,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [MC_W-1:0]  match_cnt;
    logic [MC_W-1:0]  match_nx;
    logic [MC_W-1:0]  match_inc;
    logic             href_d;
    logic             vs_d;
    logic             vs_pend;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] new_len;
    logic [CNT_W-1:0] h_total;
    logic [TO_W-1:0]  to_cnt;
    logic             href_rise;
    logic             vs_rise;
    logic             timeout;
    logic             realign;
    logic             h_wrap;
    logic             line_start;

    assign href_rise  = cam_href & ~href_d;
    assign vs_rise    = cam_vsync & ~vs_d;
    // Period just ending, counting the rise cycle itself; pinned at all-ones.
    assign new_len    = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + 1'b1;
    assign timeout    = ~href_rise && (to_cnt == TO_LAST);
    assign realign    = href_rise && (state == S_LOCKED);
    assign h_total    = (state == S_FREE) ? H_FREE : line_len;
    // >= rather than == so a shrinking h_total never lets h_cnt run away.
    assign h_wrap     = (h_cnt >= h_total - 1'b1);
    assign line_start = h_wrap | realign;
    assign match_inc  = match_cnt + 1'b1;
    assign locked     = (state == S_LOCKED);

    // Lock state and consecutive-match counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FREE;
            match_cnt <= '0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_nx;
        end
    end

    // Lock acquisition: qualify href periods, fall back to free-run on silence
    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        if (timeout) begin
            state_nx = S_FREE;
            match_nx = '0;
        end else if (href_rise) begin
            case (state)
                S_FREE: begin
                    state_nx = S_ACQUIRE;
                    match_nx = '0;
                end
                S_ACQUIRE: begin
                    if ((new_len == line_len) && (new_len >= H_MIN)) begin
                        match_nx = match_inc;
                        if (match_inc >= MC_LOCK) begin
                            state_nx = S_LOCKED;
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                S_LOCKED: begin
                    if (new_len != line_len) begin
                        state_nx = S_ACQUIRE;
                        match_nx = '0;
                    end
                end
                default: begin
                    state_nx = S_FREE;
                    match_nx = '0;
                end
            endcase
        end
    end

    // Edge history, pending frame start and href period measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            href_d   <= 1'b0;
            vs_d     <= 1'b0;
            vs_pend  <= 1'b0;
            per_cnt  <= '0;
            to_cnt   <= '0;
            line_len <= '0;
        end else begin
            href_d <= cam_href;
            vs_d   <= cam_vsync;
            if (vs_rise) begin
                vs_pend <= 1'b1;
            end else if (href_rise) begin
                vs_pend <= 1'b0;
            end
            if (href_rise) begin
                per_cnt  <= '0;
                to_cnt   <= '0;
                line_len <= new_len;
            end else begin
                per_cnt <= new_len;
                if (to_cnt != TO_SAT) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Pixel and line counters; a locked href rise restarts the line
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_start ? '0 : h_cnt + 1'b1;
            if (line_start) begin
                if (vs_pend && href_rise) begin
                    v_cnt <= '0;
                end else if (v_cnt >= V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end
        end
    end

    // Registered sync/enable decode, one clock behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
        end else begin
            de    <= (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
            hsync <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_ON : ~HS_ON;
            vsync <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_video_timing_regen.sv
// tb/tb_video_timing_regen.sv - self-checking bench for video_timing_regen
module tb_video_timing_regen;

    localparam int CNT_W   = 8;
    localparam int H_ACT   = 16;
    localparam int H_FP    = 4;
    localparam int H_SYNC  = 3;
    localparam int V_ACT   = 6;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int H_FREE  = 30;
    localparam int V_TOTAL = 12;
    localparam int LOCKN   = 2;
    localparam int TMO     = 100;
    localparam int HI      = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cam_href = 1'b0;
    logic             cam_vsync = 1'b0;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] line_len;
    logic             locked;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int               period;
        logic [CNT_W-1:0] exp_len;
        logic             exp_lock;
        bit               chk_h0;
    } vec_t;

    vec_t             tbl[14];
    vec_t             tq[$];
    logic [18:0]      fq[$];

    video_timing_regen #(
        .CNT_W(CNT_W), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .H_TOTAL_FREE(H_FREE),
        .V_TOTAL(V_TOTAL), .LOCK_LINES(LOCKN), .TIMEOUT(TMO),
        .HS_POL(1), .VS_POL(1)
    ) dut (
        .clk(clk), .rst(rst), .cam_href(cam_href), .cam_vsync(cam_vsync),
        .hsync(hsync), .vsync(vsync), .de(de), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .line_len(line_len), .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One href line of p clocks starting with a rise; mode 1 checks the rise
    // against a table entry, mode 2 checks every clock of a frame line.
    task automatic run_line(input int p, input int mode, input int vline,
                            input int vprev, input int vs_at, input vec_t e);
        vec_t        x;
        int          hd;
        int          vd;
        logic [18:0] f;
        for (int c = 0; c < p; c++) begin
            cam_href  = (c < HI);
            cam_vsync = (c == vs_at);
            if (c == 0 && mode == 1) tq.push_back(e);
            if (mode == 2 && !(c == 0 && vprev < 0)) begin
                hd = (c == 0) ? p - 1 : c - 1;
                vd = (c == 0) ? vprev : vline;
                f[18]   = (hd < H_ACT) && (vd < V_ACT);
                f[17]   = (hd >= H_ACT + H_FP) && (hd < H_ACT + H_FP + H_SYNC);
                f[16]   = (vd >= V_ACT + V_FP) && (vd < V_ACT + V_FP + V_SYNC);
                f[15:8] = 8'(c);
                f[7:0]  = 8'(vline);
                fq.push_back(f);
            end
            @(posedge clk);
            @(negedge clk);
            if (c == 0 && mode == 1) begin
                x = tq.pop_front();
                chk("line_len", 64'(line_len), 64'(x.exp_len));
                chk("locked", 64'(locked), 64'(x.exp_lock));
                if (x.chk_h0) chk("h_cnt_realign", 64'(h_cnt), 64'd0);
            end
            if (mode == 2 && fq.size() > 0) begin
                f = fq.pop_front();
                chk("frame_de_hs_vs_h_v", 64'({de, hsync, vsync, h_cnt, v_cnt}), 64'(f));
            end
        end
        cam_vsync = 1'b0;
    endtask

    task automatic lock_at(input int p);
        vec_t z;
        z = '{0, '0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) run_line(p, 0, 0, -1, -1, z);
        chk("lock_at", 64'(locked), 64'd1);
        chk("lock_at_len", 64'(line_len), 64'(p));
    endtask

    // Measures one hsync period, its high width and de-high clocks within it
    task automatic measure(output int per, output int hw, output int dn);
        logic p;
        bit   found;
        per = -1;
        hw = 0;
        dn = 0;
        p = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (hsync === 1'b1 && p === 1'b0) found = 1;
            p = hsync;
        end
        if (found) begin
            found = 0;
            for (int i = 1; i <= 200 && !found; i++) begin
                hw += int'(hsync);
                dn += int'(de);
                @(negedge clk);
                if (hsync === 1'b1 && p === 1'b0) begin
                    found = 1;
                    per = i;
                end
                p = hsync;
            end
        end
    endtask

    initial begin
        int   per;
        int   hw;
        int   dn;
        vec_t z;
        z = '{0, '0, 1'b0, 1'b0};

        // period, line_len / locked seen one clock after the rise opening this line
        tbl[0]  = '{30, 8'd255, 1'b0, 1'b0};
        tbl[1]  = '{30, 8'd30,  1'b0, 1'b0};
        tbl[2]  = '{30, 8'd30,  1'b0, 1'b0};
        tbl[3]  = '{30, 8'd30,  1'b1, 1'b0};
        tbl[4]  = '{30, 8'd30,  1'b1, 1'b1};
        tbl[5]  = '{25, 8'd30,  1'b1, 1'b1};
        tbl[6]  = '{25, 8'd25,  1'b0, 1'b1};
        tbl[7]  = '{25, 8'd25,  1'b0, 1'b0};
        tbl[8]  = '{25, 8'd25,  1'b1, 1'b0};
        tbl[9]  = '{30, 8'd25,  1'b1, 1'b1};
        tbl[10] = '{20, 8'd30,  1'b0, 1'b1};
        tbl[11] = '{20, 8'd20,  1'b0, 1'b0};
        tbl[12] = '{20, 8'd20,  1'b0, 1'b0};
        tbl[13] = '{20, 8'd20,  1'b0, 1'b0};

        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_state", 64'({hsync, vsync, de, locked, h_cnt, v_cnt, line_len}), 64'd0);
        rst = 1'b0;

        measure(per, hw, dn);
        chk("free_hsync_period", 64'(per), 64'(H_FREE));
        chk("free_hsync_width", 64'(hw), 64'(H_SYNC));
        chk("free_de_clocks", 64'(dn), 64'(H_ACT));
        chk("free_locked", 64'(locked), 64'd0);
        repeat (250) @(negedge clk);

        for (int i = 0; i < 14; i++) run_line(tbl[i].period, 1, 0, -1, -1, tbl[i]);

        lock_at(30);
        run_line(30, 0, 0, -1, 5, z);
        for (int i = 0; i <= V_TOTAL; i++)
            run_line(30, 2, i % V_TOTAL, (i == 0) ? -1 : (i - 1) % V_TOTAL, -1, z);

        lock_at(25);
        repeat (TMO - 27) @(negedge clk);
        chk("timeout_not_yet", 64'(locked), 64'd1);
        repeat (6) @(negedge clk);
        chk("timeout_unlocked", 64'(locked), 64'd0);
        measure(per, hw, dn);
        chk("timeout_free_period", 64'(per), 64'(H_FREE));
        chk("timeout_free_width", 64'(hw), 64'(H_SYNC));

        for (int i = 0; i < 3; i++) run_line(30, 0, 0, -1, -1, z);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_midframe", 64'({hsync, vsync, de, locked, h_cnt, v_cnt, line_len}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
